// File: rtl/board_io_cond.sv
// Board-level I/O conditioning: button synchronise/debounce with press/release
// strobes, LED stretching with pin polarity, and a power-on/button system reset.
module board_io_cond #(
    parameter int                NBTN               = 4,
    parameter logic [NBTN-1:0]   BTN_ACTIVE_LOW     = {NBTN{1'b1}},
    parameter int                DEBOUNCE_CYCLES    = 500000,
    parameter int                NLED               = 8,
    parameter logic [NLED-1:0]   LED_ACTIVE_LOW     = '0,
    parameter int                LED_STRETCH_CYCLES = 2500000,
    parameter int                POR_CYCLES         = 65536,
    parameter int                RST_BTN            = 0
) (
    input  logic            CLK_50MHZ,
    input  logic            RESET,
    input  logic [NBTN-1:0] BTN_RAW,
    output logic [NBTN-1:0] BTN_LEVEL,
    output logic [NBTN-1:0] BTN_PRESS,
    output logic [NBTN-1:0] BTN_RELEASE,
    input  logic [NLED-1:0] LED_IN,
    output logic [NLED-1:0] LED_OUT,
    output logic            SYS_RESET
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    localparam int SCW = (LED_STRETCH_CYCLES > 0) ? $clog2(LED_STRETCH_CYCLES + 1) : 1;
    localparam logic [SCW-1:0] STRETCH_LOAD = SCW'(LED_STRETCH_CYCLES);

    localparam int PCW = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam logic [PCW-1:0] POR_LAST = PCW'(POR_CYCLES - 1);

    // ---------------------------------------------------------------- buttons
    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        logic           sync1;
        logic           sync2;
        logic           norm;
        logic [DCW-1:0] deb_cnt;
        logic           level_q;
        logic           press_q;
        logic           release_q;

        assign norm = sync2 ^ BTN_ACTIVE_LOW[i];

        always_ff @(posedge CLK_50MHZ or posedge RESET) begin
            if (RESET) begin
                sync1     <= BTN_ACTIVE_LOW[i];
                sync2     <= BTN_ACTIVE_LOW[i];
                deb_cnt   <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1     <= BTN_RAW[i];
                sync2     <= sync1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                // Any return to the accepted level discards accumulated credit.
                if (norm == level_q) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_LAST) begin
                    deb_cnt   <= '0;
                    level_q   <= norm;
                    press_q   <= norm;
                    release_q <= ~norm;
                end else begin
                    deb_cnt <= deb_cnt + DCW'(1);
                end
            end
        end

        assign BTN_LEVEL[i]   = level_q;
        assign BTN_PRESS[i]   = press_q;
        assign BTN_RELEASE[i] = release_q;
    end

    // ------------------------------------------------------------------- LEDs
    for (genvar j = 0; j < NLED; j++) begin : g_led
        logic [SCW-1:0] str_cnt;
        logic           active;
        logic           out_q;

        assign active = LED_IN[j] | (str_cnt != '0);

        always_ff @(posedge CLK_50MHZ or posedge RESET) begin
            if (RESET) begin
                str_cnt <= '0;
                out_q   <= LED_ACTIVE_LOW[j];
            end else begin
                if (LED_IN[j]) begin
                    str_cnt <= STRETCH_LOAD;
                end else if (str_cnt != '0) begin
                    str_cnt <= str_cnt - SCW'(1);
                end
                out_q <= active ^ LED_ACTIVE_LOW[j];
            end
        end

        assign LED_OUT[j] = out_q;
    end

    // -------------------------------------------------------- reset generator
    logic rst_req;

    if (RST_BTN >= 0 && RST_BTN < NBTN) begin : g_rst_btn
        assign rst_req = BTN_LEVEL[RST_BTN];
    end else begin : g_no_rst_btn
        assign rst_req = 1'b0;
    end

    typedef enum logic {
        HOLD,
        RUN
    } por_state_t;

    por_state_t     por_state;
    logic [PCW-1:0] por_cnt;
    logic           sys_reset_q;

    always_ff @(posedge CLK_50MHZ or posedge RESET) begin
        if (RESET) begin
            por_state   <= HOLD;
            por_cnt     <= '0;
            sys_reset_q <= 1'b1;
        end else if (rst_req) begin
            // Held button pins the count at zero; timing restarts on release.
            por_state   <= HOLD;
            por_cnt     <= '0;
            sys_reset_q <= 1'b1;
        end else begin
            case (por_state)
                HOLD: begin
                    if (por_cnt == POR_LAST) begin
                        por_state   <= RUN;
                        por_cnt     <= '0;
                        sys_reset_q <= 1'b0;
                    end else begin
                        por_cnt     <= por_cnt + PCW'(1);
                        sys_reset_q <= 1'b1;
                    end
                end
                RUN: begin
                    sys_reset_q <= 1'b0;
                end
                default: begin
                    por_state   <= HOLD;
                    por_cnt     <= '0;
                    sys_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign SYS_RESET = sys_reset_q;

endmodule

// File: tb/tb_board_io_cond.sv
// Directed bench for board_io_cond: POR, debounce, glitch rejection, reset
// button, LED stretch (normal and inverted polarity) and asynchronous reset.
module tb_board_io_cond;

    logic       clk;
    logic       RESET;
    logic [3:0] BTN_RAW;
    logic [7:0] LED_IN;

    logic [3:0] btn_level, btn_press, btn_release;
    logic [7:0] led_out;
    logic       sys_reset;

    logic [3:0] inv_level, inv_press, inv_release;
    logic [7:0] inv_led_out;
    logic       inv_sys_reset;

    int checks   = 0;
    int failures = 0;

    board_io_cond #(
        .NBTN(4), .BTN_ACTIVE_LOW(4'hF), .DEBOUNCE_CYCLES(4),
        .NLED(8), .LED_ACTIVE_LOW(8'h00), .LED_STRETCH_CYCLES(8),
        .POR_CYCLES(16), .RST_BTN(0)
    ) dut (
        .CLK_50MHZ(clk), .RESET(RESET), .BTN_RAW(BTN_RAW),
        .BTN_LEVEL(btn_level), .BTN_PRESS(btn_press), .BTN_RELEASE(btn_release),
        .LED_IN(LED_IN), .LED_OUT(led_out), .SYS_RESET(sys_reset)
    );

    board_io_cond #(
        .NBTN(4), .BTN_ACTIVE_LOW(4'hF), .DEBOUNCE_CYCLES(4),
        .NLED(8), .LED_ACTIVE_LOW(8'h02), .LED_STRETCH_CYCLES(8),
        .POR_CYCLES(16), .RST_BTN(0)
    ) dut_inv (
        .CLK_50MHZ(clk), .RESET(RESET), .BTN_RAW(BTN_RAW),
        .BTN_LEVEL(inv_level), .BTN_PRESS(inv_press), .BTN_RELEASE(inv_release),
        .LED_IN(LED_IN), .LED_OUT(inv_led_out), .SYS_RESET(inv_sys_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RESET   = 1'b1;
        BTN_RAW = 4'hF;
        LED_IN  = 8'h00;
        #1;
        checks++;
        if (sys_reset !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_clock_sys_reset got=%b exp=1", sys_reset);
        end
        repeat (3) tick();
        checks++;
        if (sys_reset !== 1'b1) begin
            failures++;
            $display("FAIL reset_sys_reset got=%b exp=1", sys_reset);
        end
        checks++;
        if ({btn_level, btn_press, btn_release} !== 12'h000) begin
            failures++;
            $display("FAIL reset_btn got=%h exp=000", {btn_level, btn_press, btn_release});
        end
        checks++;
        if (led_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_led got=%h exp=00", led_out);
        end
        checks++;
        if (inv_led_out !== 8'h02) begin
            failures++;
            $display("FAIL reset_led_inv got=%h exp=02", inv_led_out);
        end
    endtask

    task automatic test_por();
        RESET = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (sys_reset !== (k < 16)) begin
                failures++;
                $display("FAIL por_sys_reset edge=%0d got=%b exp=%b", k, sys_reset, (k < 16));
            end
            checks++;
            if (btn_level !== 4'h0 || led_out !== 8'h00) begin
                failures++;
                $display("FAIL por_idle edge=%0d got=%h/%h exp=0/00", k, btn_level, led_out);
            end
        end
    endtask

    task automatic test_debounce();
        logic [3:0] exp_lvl, exp_pr, exp_rl;
        BTN_RAW[1] = 1'b0;
        for (int k = 21; k <= 50; k++) begin
            tick();
            exp_lvl = (k >= 26 && k < 46) ? 4'b0010 : 4'b0000;
            exp_pr  = (k == 26) ? 4'b0010 : 4'b0000;
            exp_rl  = (k == 46) ? 4'b0010 : 4'b0000;
            checks++;
            if (btn_level !== exp_lvl) begin
                failures++;
                $display("FAIL debounce_level edge=%0d got=%b exp=%b", k, btn_level, exp_lvl);
            end
            checks++;
            if (btn_press !== exp_pr || btn_release !== exp_rl) begin
                failures++;
                $display("FAIL debounce_strobe edge=%0d got=%b/%b exp=%b/%b",
                         k, btn_press, btn_release, exp_pr, exp_rl);
            end
            checks++;
            if (sys_reset !== 1'b0) begin
                failures++;
                $display("FAIL debounce_sys_reset edge=%0d got=%b exp=0", k, sys_reset);
            end
            if (k == 40) BTN_RAW[1] = 1'b1;
        end
    endtask

    task automatic test_glitch();
        BTN_RAW[2] = 1'b0;
        for (int s = 1; s <= 14; s++) begin
            tick();
            checks++;
            if (btn_level !== 4'h0 || btn_press !== 4'h0 || btn_release !== 4'h0) begin
                failures++;
                $display("FAIL glitch step=%0d got=%b/%b/%b exp=0000/0000/0000",
                         s, btn_level, btn_press, btn_release);
            end
            if (s == 3) BTN_RAW[2] = 1'b1;
            if (s == 4) BTN_RAW[2] = 1'b0;
            if (s == 7) BTN_RAW[2] = 1'b1;
        end
    endtask

    task automatic test_reset_btn();
        checks++;
        if (sys_reset !== 1'b0) begin
            failures++;
            $display("FAIL rstbtn_idle got=%b exp=0", sys_reset);
        end
        BTN_RAW[0] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            checks++;
            if (sys_reset !== (k >= 7 && k < 32)) begin
                failures++;
                $display("FAIL rstbtn_sys_reset edge=%0d got=%b exp=%b", k, sys_reset, (k >= 7 && k < 32));
            end
            checks++;
            if (btn_level[0] !== (k >= 6 && k < 16)) begin
                failures++;
                $display("FAIL rstbtn_level edge=%0d got=%b exp=%b", k, btn_level[0], (k >= 6 && k < 16));
            end
            if (k == 10) BTN_RAW[0] = 1'b1;
        end
    endtask

    task automatic test_led_stretch();
        logic [7:0] exp;
        LED_IN = 8'h02;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = (k <= 9) ? 8'h02 : 8'h00;
            checks++;
            if (led_out !== exp || inv_led_out !== (exp ^ 8'h02)) begin
                failures++;
                $display("FAIL led_single edge=%0d got=%h/%h exp=%h/%h", k, led_out, inv_led_out, exp, exp ^ 8'h02);
            end
            if (k == 1) LED_IN = 8'h00;
        end
        LED_IN = 8'h02;
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp = (k <= 14) ? 8'h02 : 8'h00;
            checks++;
            if (led_out !== exp || inv_led_out !== (exp ^ 8'h02)) begin
                failures++;
                $display("FAIL led_retrigger edge=%0d got=%h/%h exp=%h/%h", k, led_out, inv_led_out, exp, exp ^ 8'h02);
            end
            if (k == 1) LED_IN = 8'h00;
            if (k == 5) LED_IN = 8'h02;
            if (k == 6) LED_IN = 8'h00;
        end
    endtask

    task automatic test_led_multi();
        logic [7:0] exp;
        LED_IN = 8'hA0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp = (k <= 11) ? 8'hA0 : 8'h00;
            checks++;
            if (led_out !== exp || inv_led_out !== (exp ^ 8'h02)) begin
                failures++;
                $display("FAIL led_multi edge=%0d got=%h/%h exp=%h/%h", k, led_out, inv_led_out, exp, exp ^ 8'h02);
            end
            if (k == 3) LED_IN = 8'h00;
        end
    endtask

    task automatic test_async_reset();
        BTN_RAW[3] = 1'b0;
        repeat (6) tick();
        checks++;
        if (btn_level !== 4'b1000) begin
            failures++;
            $display("FAIL async_pre_level got=%b exp=1000", btn_level);
        end
        BTN_RAW[3] = 1'b1;
        LED_IN     = 8'h10;
        tick();
        LED_IN     = 8'h00;
        tick();
        tick();
        checks++;
        if (led_out !== 8'h10 || inv_led_out !== 8'h12) begin
            failures++;
            $display("FAIL async_pre_led got=%h/%h exp=10/12", led_out, inv_led_out);
        end
        #3;
        RESET = 1'b1;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release} !== 12'h000) begin
            failures++;
            $display("FAIL async_btn got=%h exp=000", {btn_level, btn_press, btn_release});
        end
        checks++;
        if (led_out !== 8'h00 || inv_led_out !== 8'h02) begin
            failures++;
            $display("FAIL async_led got=%h/%h exp=00/02", led_out, inv_led_out);
        end
        checks++;
        if (sys_reset !== 1'b1 || inv_sys_reset !== 1'b1) begin
            failures++;
            $display("FAIL async_sys_reset got=%b/%b exp=1/1", sys_reset, inv_sys_reset);
        end
        tick();
        RESET = 1'b0;
        tick();
        tick();
        checks++;
        if (led_out !== 8'h00 || btn_level !== 4'h0 || sys_reset !== 1'b1) begin
            failures++;
            $display("FAIL async_after got=%h/%b/%b exp=00/0000/1", led_out, btn_level, sys_reset);
        end
    endtask

    initial begin
        test_reset();
        test_por();
        test_debounce();
        test_glitch();
        test_reset_btn();
        test_led_stretch();
        test_led_multi();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
